rst_sequencer: RTL and testbench

//  Generates the board-level reset sequence for the ADC test datapath, upstream of
//  the per-domain reset synchronizers.
//  - Holds the clocking MMCM in reset and waits for lock.
//  - Then releases NUM_STAGES downstream active-low resets one at a time, in index order.
//  - Restarts the whole sequence on lock loss, lock timeout or a software request.

---
 rtl/rst_sequencer_pkg.sv | 26 ++
 rtl/rst_sequencer_if.sv | 37 +++
 rtl/rst_sequencer_bit_sync.sv | 24 ++
 rtl/rst_sequencer.sv | 157 +++++++++++++++
 tb/tb_rst_sequencer.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/rst_sequencer_pkg.sv
// Shared types and sizing helpers for the board-level reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_RELEASE,
        S_RUN
    } rst_state_t;

    localparam int RETRY_W = 8;

    // Width able to hold the largest terminal count of any timed phase.
    function automatic int cnt_width(input int hold_cycles,
                                     input int lock_timeout,
                                     input int stage_gap,
                                     input int lock_stable);
        int m;
        m = hold_cycles;
        if (lock_timeout > m) m = lock_timeout;
        if (stage_gap > m)    m = stage_gap;
        if (lock_stable > m)  m = lock_stable;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// Lock/request inputs and staged reset outputs of the reset sequencer.
interface rst_sequencer_if
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES = 3
);

    logic                  mmcm_locked;
    logic                  sw_rst_req;
    logic                  pll_rst;
    logic [NUM_STAGES-1:0] rst_stage_n;
    logic                  seq_done;
    logic                  lock_err;
    logic [RETRY_W-1:0]    retry_cnt;

    // The sequencer side drives the resets and status.
    modport master (
        input  mmcm_locked,
        input  sw_rst_req,
        output pll_rst,
        output rst_stage_n,
        output seq_done,
        output lock_err,
        output retry_cnt
    );

    modport slave (
        output mmcm_locked,
        output sw_rst_req,
        input  pll_rst,
        input  rst_stage_n,
        input  seq_done,
        input  lock_err,
        input  retry_cnt
    );

endinterface

// File: rtl/rst_sequencer_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level, cleared by asyncrst.
module bit_sync (
    input  logic clk,
    input  logic asyncrst,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk or posedge asyncrst) begin
        if (asyncrst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/rst_sequencer.sv
// Board reset sequencer: MMCM hold/lock wait, then staged release of active-low resets.
// Optional LOCK_DEBOUNCE_EN requires LOCK_STABLE consecutive locked cycles before release.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES  = 8,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int NUM_STAGES   = 3,
    parameter int STAGE_GAP    = 16,
    parameter int LOCK_STABLE  = 16
) (
    input logic             clk,
    input logic             asyncrst,
    rst_sequencer_if.master bus
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, LOCK_TIMEOUT, STAGE_GAP, LOCK_STABLE);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_STAGES - 1);

    rst_state_t            state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [NUM_STAGES-1:0] stage_n, stage_n_nxt;
    logic                  pll_rst_q;
    logic                  seq_done_q;
    logic                  lock_err_q;
    logic [RETRY_W-1:0]    retry_q;
    logic                  timeout;
    logic                  lock_s;
    logic                  lock_ok;

    bit_sync u_lock_sync (
        .clk      (clk),
        .asyncrst (asyncrst),
        .d        (bus.mmcm_locked),
        .q        (lock_s)
    );

`ifdef LOCK_DEBOUNCE_EN
    logic [CNT_W-1:0] stab_cnt;

    // Counts consecutive locked cycles only while waiting; any gap starts over.
    always_ff @(posedge clk or posedge asyncrst) begin
        if (asyncrst) begin
            stab_cnt <= '0;
        end else if (state == S_WAIT_LOCK && lock_s && !bus.sw_rst_req) begin
            stab_cnt <= stab_cnt + CNT_W'(1);
        end else begin
            stab_cnt <= '0;
        end
    end

    assign lock_ok = lock_s && (stab_cnt == CNT_W'(LOCK_STABLE - 1));
`else
    assign lock_ok = lock_s;
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_W'(1);
        idx_nxt     = idx;
        stage_n_nxt = stage_n;
        timeout     = 1'b0;
        case (state)
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_ok) begin
                    state_nxt = S_RELEASE;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = '0;
                    timeout   = 1'b1;
                end
            end
            S_RELEASE: begin
                if (!lock_s) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = '0;
                end else if (cnt == GAP_LAST) begin
                    cnt_nxt     = '0;
                    stage_n_nxt = stage_n | (NUM_STAGES'(1) << idx);
                    if (idx == IDX_LAST) begin
                        state_nxt = S_RUN;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            S_RUN: begin
                cnt_nxt = cnt;
                if (!lock_s) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_HOLD;
                cnt_nxt   = '0;
            end
        endcase
        // A software request overrides any lock event or timeout in the same cycle.
        if (bus.sw_rst_req) begin
            state_nxt = S_HOLD;
            cnt_nxt   = '0;
            timeout   = 1'b0;
        end
        if (state_nxt == S_HOLD) begin
            stage_n_nxt = '0;
        end
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge clk or posedge asyncrst) begin
        if (asyncrst) begin
            state      <= S_HOLD;
            cnt        <= '0;
            idx        <= '0;
            stage_n    <= '0;
            pll_rst_q  <= 1'b1;
            seq_done_q <= 1'b0;
            lock_err_q <= 1'b0;
            retry_q    <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            stage_n    <= stage_n_nxt;
            pll_rst_q  <= (state_nxt == S_HOLD);
            seq_done_q <= (state_nxt == S_RUN);
            if (timeout) begin
                lock_err_q <= 1'b1;
                if (retry_q != '1) begin
                    retry_q <= retry_q + RETRY_W'(1);
                end
            end
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.rst_stage_n = stage_n;
    assign bus.seq_done    = seq_done_q;
    assign bus.lock_err    = lock_err_q;
    assign bus.retry_cnt   = retry_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer (HOLD=8, TIMEOUT=100, STAGES=3, GAP=4, STABLE=16).
module tb_rst_sequencer;

    logic clk;
    logic clk_en;
    logic asyncrst;
    int   cyc;
    int   checks;
    int   errors;

`ifdef LOCK_DEBOUNCE_EN
    localparam int D = 15;
`else
    localparam int D = 0;
`endif

    rst_sequencer_if #(.NUM_STAGES(3)) bus ();

    rst_sequencer #(
        .HOLD_CYCLES  (8),
        .LOCK_TIMEOUT (100),
        .NUM_STAGES   (3),
        .STAGE_GAP    (4),
        .LOCK_STABLE  (16)
    ) dut (
        .clk      (clk),
        .asyncrst (asyncrst),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    // Edges since the last reset release.
    always @(posedge clk or posedge asyncrst) begin
        if (asyncrst) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic at(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst_vals(input string tag);
        chk({tag, "_pll"},   32'(bus.pll_rst),     32'd1);
        chk({tag, "_stage"}, 32'(bus.rst_stage_n), 32'd0);
        chk({tag, "_done"},  32'(bus.seq_done),    32'd0);
        chk({tag, "_err"},   32'(bus.lock_err),    32'd0);
        chk({tag, "_retry"}, 32'(bus.retry_cnt),   32'd0);
    endtask

    int t, l, h, r, s, r2, p, r3;

    initial begin
        checks          = 0;
        errors          = 0;
        clk_en          = 1'b1;
        asyncrst        = 1'b1;
        bus.mmcm_locked = 1'b0;
        bus.sw_rst_req  = 1'b0;
        repeat (3) @(negedge clk);
        chk_rst_vals("reset");
        asyncrst = 1'b0;

        // Power-up sequence
        at(7);  chk("hold_7",  32'(bus.pll_rst), 32'd1);
        at(8);  chk("hold_8",  32'(bus.pll_rst), 32'd0);
        at(20); bus.mmcm_locked = 1'b1;
        t = 23 + D;
        at(t + 3);  chk("rel_pre",  32'(bus.rst_stage_n), 32'b000);
        at(t + 4);  chk("rel_s0",   32'(bus.rst_stage_n), 32'b001);
        at(t + 8);  chk("rel_s1",   32'(bus.rst_stage_n), 32'b011);
        at(t + 11); chk("rel_nd",   32'(bus.seq_done),    32'd0);
        at(t + 12); chk("rel_s2",   32'(bus.rst_stage_n), 32'b111);
                    chk("rel_done", 32'(bus.seq_done),    32'd1);

        // Lock loss in S_RUN
        at(t + 13); bus.mmcm_locked = 1'b0; l = t + 13;
        at(l + 2);  chk("loss_e2_stage", 32'(bus.rst_stage_n), 32'b111);
                    chk("loss_e2_done",  32'(bus.seq_done),    32'd1);
        at(l + 3);  chk("loss_e3_stage", 32'(bus.rst_stage_n), 32'b000);
                    chk("loss_e3_pll",   32'(bus.pll_rst),     32'd1);
                    chk("loss_e3_done",  32'(bus.seq_done),    32'd0);
        h = l + 3; bus.mmcm_locked = 1'b1;
        at(h + 7);  chk("relock_hold", 32'(bus.pll_rst), 32'd1);
        at(h + 8);  chk("relock_wait", 32'(bus.pll_rst), 32'd0);
        r = h + 9 + D;
        at(r + 4);  chk("relock_s0",   32'(bus.rst_stage_n), 32'b001);
        at(r + 12); chk("relock_s2",   32'(bus.rst_stage_n), 32'b111);
                    chk("relock_done", 32'(bus.seq_done),    32'd1);

        // Software request in S_RUN, then mid-S_RELEASE
        at(r + 14); bus.sw_rst_req = 1'b1;
        at(r + 15); bus.sw_rst_req = 1'b0; s = r + 15;
        chk("swrun_pll",   32'(bus.pll_rst),     32'd1);
        chk("swrun_stage", 32'(bus.rst_stage_n), 32'b000);
        chk("swrun_done",  32'(bus.seq_done),    32'd0);
        chk("swrun_err",   32'(bus.lock_err),    32'd0);
        r2 = s + 9 + D;
        at(r2 + 5); chk("swrel_pre", 32'(bus.rst_stage_n), 32'b001);
        bus.sw_rst_req = 1'b1;
        at(r2 + 6); bus.sw_rst_req = 1'b0; p = r2 + 6;
        chk("swrel_stage", 32'(bus.rst_stage_n), 32'b000);
        chk("swrel_pll",   32'(bus.pll_rst),     32'd1);

        // Asynchronous reset with the clock stopped
        r3 = p + 9 + D;
        at(r3 + 5); chk("ar_pre_stage", 32'(bus.rst_stage_n), 32'b001);
                    chk("ar_pre_pll",   32'(bus.pll_rst),     32'd0);
        clk_en = 1'b0;
        #7;
        asyncrst = 1'b1;
        #2;
        chk_rst_vals("async");
        #20;
        clk_en = 1'b1;
        bus.mmcm_locked = 1'b0;
        repeat (3) @(negedge clk);
        asyncrst = 1'b0;

        // Lock timeouts and retry count
        at(107); chk("to1_pre_err",   32'(bus.lock_err),  32'd0);
                 chk("to1_pre_retry", 32'(bus.retry_cnt), 32'd0);
                 chk("to1_pre_pll",   32'(bus.pll_rst),   32'd0);
        at(108); chk("to1_err",       32'(bus.lock_err),  32'd1);
                 chk("to1_retry",     32'(bus.retry_cnt), 32'd1);
                 chk("to1_pll",       32'(bus.pll_rst),   32'd1);
        at(115); chk("to1_hold",      32'(bus.pll_rst),   32'd1);
        at(116); chk("to1_wait",      32'(bus.pll_rst),   32'd0);
        at(215); chk("to2_pre_retry", 32'(bus.retry_cnt), 32'd1);
        at(216); chk("to2_retry",     32'(bus.retry_cnt), 32'd2);

        // Software request restarts the hold count and keeps error status
        at(220); bus.sw_rst_req = 1'b1;
        at(221); bus.sw_rst_req = 1'b0;
        at(228); chk("swhold_pll",   32'(bus.pll_rst),   32'd1);
        at(229); chk("swhold_wait",  32'(bus.pll_rst),   32'd0);
                 chk("swhold_err",   32'(bus.lock_err),  32'd1);
                 chk("swhold_retry", 32'(bus.retry_cnt), 32'd2);

        // Short lock pulse, then steady lock
        bus.mmcm_locked = 1'b1;
        at(239); bus.mmcm_locked = 1'b0;
`ifdef LOCK_DEBOUNCE_EN
        chk("db_short_stage", 32'(bus.rst_stage_n), 32'b000);
        at(242); chk("db_short_pll", 32'(bus.pll_rst), 32'd0);
        at(250); bus.mmcm_locked = 1'b1;
        at(271); chk("db_pre_s0", 32'(bus.rst_stage_n), 32'b000);
        at(272); chk("db_s0",     32'(bus.rst_stage_n), 32'b001);
`else
        at(236); chk("nd_short_s0",  32'(bus.rst_stage_n), 32'b001);
        at(242); chk("nd_short_pll", 32'(bus.pll_rst),     32'd1);
        at(250); bus.mmcm_locked = 1'b1;
        at(256); chk("nd_pre_s0", 32'(bus.rst_stage_n), 32'b000);
        at(257); chk("nd_s0",     32'(bus.rst_stage_n), 32'b001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
